// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the two-requester ALU scheduler.
// Optional feature macro: ALU_SCHED_STATS_EN (per-requester completion counters).
package alu_sched_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } sched_state_t;

  // ALU control codes, matching the Alu control input
  typedef logic [1:0] alu_op_t;
  localparam alu_op_t OP_ADD = 2'b00;
  localparam alu_op_t OP_SUB = 2'b01;
  localparam alu_op_t OP_AND = 2'b10;
  localparam alu_op_t OP_OR  = 2'b11;

  // Width of the optional completion counters
  localparam int STATS_W = 8;

  // Requester index -> one-hot pulse vector
  function automatic logic [1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: picks a requester from req and the
// priority pointer, and reports what the pointer becomes after a grant.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic       valid,
  output logic       idx,
  output logic       prio_next
);

  // A lone requester wins outright; contention is settled by prio.
  always_comb begin
    valid     = |req;
    idx       = (req == 2'b11) ? prio : req[1];
    prio_next = ~idx;
  end

endmodule

// File: rtl/alu_share_sched.sv
// Shares one combinational ALU between two requesters: latch operands of the
// granted requester, let the ALU settle for one cycle, register its outputs
// and pulse done back to that requester.
// Optional feature macro: ALU_SCHED_STATS_EN adds cnt0/cnt1 completion counters.
module alu_share_sched
  import alu_sched_pkg::*;
#(
  parameter int Bits = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req,
  input  logic [Bits-1:0] a0,
  input  logic [Bits-1:0] b0,
  input  alu_op_t         op0,
  input  logic [Bits-1:0] a1,
  input  logic [Bits-1:0] b1,
  input  alu_op_t         op1,
  output logic [1:0]      gnt,
  output logic [1:0]      done,
  output logic [Bits-1:0] result,
  output logic [3:0]      flags,
  output logic            busy,
  output logic [Bits-1:0] alu_a,
  output logic [Bits-1:0] alu_b,
  output alu_op_t         alu_ctrl,
`ifdef ALU_SCHED_STATS_EN
  output logic [STATS_W-1:0] cnt0,
  output logic [STATS_W-1:0] cnt1,
`endif
  input  logic [Bits-1:0] alu_result,
  input  logic [3:0]      alu_flags
);

  sched_state_t    state_q, state_d;
  logic            prio_q;
  logic            sel_q;
  logic [Bits-1:0] alu_a_q, alu_b_q;
  alu_op_t         alu_ctrl_q;
  logic [Bits-1:0] result_q;
  logic [3:0]      flags_q;

  logic arb_valid, arb_idx, arb_prio_next;

  rr_arbiter2 u_arb (
    .req       (req),
    .prio      (prio_q),
    .valid     (arb_valid),
    .idx       (arb_idx),
    .prio_next (arb_prio_next)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: requests are only looked at in IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (arb_valid) state_d = ST_ISSUE;
      ST_ISSUE:   state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Operand latch on grant, result capture after the ALU has had a cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q     <= 1'b0;
      sel_q      <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctrl_q <= OP_ADD;
      result_q   <= '0;
      flags_q    <= '0;
    end else begin
      if (state_q == ST_IDLE && arb_valid) begin
        sel_q      <= arb_idx;
        prio_q     <= arb_prio_next;
        alu_a_q    <= arb_idx ? a1  : a0;
        alu_b_q    <= arb_idx ? b1  : b0;
        alu_ctrl_q <= arb_idx ? op1 : op0;
      end
      if (state_q == ST_ISSUE) begin
        result_q <= alu_result;
        flags_q  <= alu_flags;
      end
    end
  end

  // Outputs: pulses decoded from state and the latched requester index
  always_comb begin
    gnt  = (state_q == ST_ISSUE)   ? idx_to_onehot(sel_q) : 2'b00;
    done = (state_q == ST_CAPTURE) ? idx_to_onehot(sel_q) : 2'b00;
    busy = (state_q != ST_IDLE);
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_ctrl = alu_ctrl_q;
  assign result   = result_q;
  assign flags    = flags_q;

`ifdef ALU_SCHED_STATS_EN
  logic [STATS_W-1:0] cnt0_q, cnt1_q;

  // Saturating per-requester completion counters, bumped on CAPTURE
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (state_q == ST_CAPTURE) begin
      if (!sel_q && cnt0_q != '1) cnt0_q <= cnt0_q + 1'b1;
      if ( sel_q && cnt1_q != '1) cnt1_q <= cnt1_q + 1'b1;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule
